// File: rtl/operand_loader_pkg.sv
// -----------------------------------------------------------------------------
// operand_loader_pkg
//
// Shared definitions for the operand loader front end.
//   - DEFAULT_DATA_W : default operand word width (operand memory word).
//   - DEFAULT_PAIRS  : default operand pairs per frame (frame = 2*PAIRS words).
//   - STATE_W        : width of the loader state encoding.
//   - state_e        : loader states IDLE, FILL, SETTLE, KICK, WAIT, DONE.
// -----------------------------------------------------------------------------
package operand_loader_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_PAIRS  = 8;
    localparam int STATE_W        = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_KICK   = 3'd3,
        ST_WAIT   = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

endpackage

// File: rtl/operand_loader_wr_addr_counter.sv
// -----------------------------------------------------------------------------
// wr_addr_counter
//
// Operand memory write address counter for the operand loader.
// Clear has priority over increment. Incrementing from the last word address
// (WORDS-1) wraps back to 0, so a finished frame leaves the counter at 0 even
// when WORDS is not a power of two.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset (counter -> 0)
//   clr_i  in   synchronous clear to address 0
//   inc_i  in   advance to the next address
//   addr_o out  current address (registered)
//   tc_o   out  terminal count: current address is WORDS-1
// -----------------------------------------------------------------------------
module wr_addr_counter
    import operand_loader_pkg::*;
#(
    parameter int WORDS  = 2 * DEFAULT_PAIRS,
    parameter int ADDR_W = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              tc_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    assign tc_o   = (addr_q == LAST_ADDR);
    assign addr_o = addr_q;

    always_comb begin
        addr_d = addr_q;
        if (clr_i) begin
            addr_d = '0;
        end else if (inc_i) begin
            addr_d = tc_o ? '0 : addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/operand_loader.sv
// -----------------------------------------------------------------------------
// operand_loader
//
// Front end of the approximate-multiplier core. Streams one frame of
// 2*PAIRS operand words into the operand memory (word k -> address k; even
// address = first operand, odd = second operand of a pair), pulses `start`
// to the multiplier controller, then waits for `mult_done` before finishing
// the frame with a one-cycle `frame_done`.
//
// Build option:
//   OPERAND_LOADER_AUTO_REARM_EN  when defined, DONE goes straight back to
//                                 FILL (address 0) so frames run back to back
//                                 after a single `arm`. When undefined, DONE
//                                 returns to IDLE and every frame needs `arm`.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   arm         in   load one frame; only looked at in IDLE
//   in_data     in   operand word
//   in_valid    in   in_data valid
//   in_ready    out  loader takes a word this cycle (registered)
//   wr_en       out  operand memory write enable (registered)
//   wr_addr     out  operand memory write address (registered)
//   wr_data     out  operand memory write data (registered)
//   start       out  one-cycle start pulse to the controller (registered)
//   mult_done   in   controller done pulse; only looked at in WAIT
//   busy        out  state is not IDLE (combinational from state)
//   frame_done  out  one-cycle pulse at the end of a frame (registered)
//   state_dbg   out  current FSM state, for observation only
//
// Handshake: a word transfers on a rising edge where in_valid and in_ready
// are both high. in_ready never depends on in_valid in the same cycle; the
// source may raise or drop in_valid at any time, and a word offered while
// in_ready is low is simply not taken.
// -----------------------------------------------------------------------------
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int PAIRS  = DEFAULT_PAIRS,
    parameter int ADDR_W = $clog2(2 * PAIRS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arm,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [DATA_W-1:0]  wr_data,
    output logic               start,
    input  logic               mult_done,
    output logic               busy,
    output logic               frame_done,
    output logic [STATE_W-1:0] state_dbg
);

    localparam int WORDS = 2 * PAIRS;

    state_e            state_q;
    state_e            state_d;

    logic              in_ready_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              start_q;
    logic              frame_done_q;

    logic              accept;
    logic              cnt_clr;
    logic              cnt_inc;
    logic [ADDR_W-1:0] cnt_addr;
    logic              cnt_tc;

    // in_ready_q is only ever high while in FILL, so this is the FILL accept.
    assign accept = in_valid & in_ready_q;

    wr_addr_counter #(
        .WORDS  (WORDS),
        .ADDR_W (ADDR_W)
    ) u_wr_addr_counter (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .addr_o (cnt_addr),
        .tc_o   (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d = ST_FILL;
                    cnt_clr = 1'b1;
                end
            end
            ST_FILL: begin
                if (accept) begin
                    cnt_inc = 1'b1;
                    if (cnt_tc) begin
                        state_d = ST_SETTLE;
                    end
                end
            end
            // The last word's registered write is on the port during SETTLE,
            // so the memory holds the full frame before start is raised.
            ST_SETTLE: state_d = ST_KICK;
            ST_KICK:   state_d = ST_WAIT;
            ST_WAIT: begin
                if (mult_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
`ifdef OPERAND_LOADER_AUTO_REARM_EN
                state_d = ST_FILL;
                cnt_clr = 1'b1;
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs are decoded from the next state so that each one
    // lines up exactly with the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            in_ready_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            start_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= (state_d == ST_FILL);
            start_q      <= (state_d == ST_KICK);
            frame_done_q <= (state_d == ST_DONE);
            wr_en_q      <= accept;
            if (accept) begin
                wr_addr_q <= cnt_addr;
                wr_data_q <= in_data;
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign start      = start_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != ST_IDLE);
    assign state_dbg  = state_q;

endmodule

// File: doc/operand_loader.md
# operand_loader

Front-end stage for the approximate-multiplier core. It accepts a stream of 16-bit operand words over a valid/ready handshake and writes them, in order, into the core's operand memory. Once a full frame is written it pulses the multiplier controller's `start`, then holds off further input until the controller reports `done`. It sits directly upstream of the multiplier controller and shares the operand memory write port with nothing else.

## Interface
- `DATA_W`, 16, operand word width (matches operand memory word).
- `PAIRS`, 8, operand pairs per frame; frame length is WORDS = 2*PAIRS.
- `ADDR_W`, $clog2(2*PAIRS), operand memory address width.

- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `arm`  in  1  request to load one frame; sampled in IDLE only.
- `in_data`  in  DATA_W  operand word.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader accepts a word this cycle.
- `wr_en`  out  1  operand memory write enable (registered).
- `wr_addr`  out  ADDR_W  operand memory write address (registered).
- `wr_data`  out  DATA_W  operand memory write data (registered).
- `start`  out  1  one-cycle start pulse to multiplier controller.
- `mult_done`  in  1  controller `done` pulse.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse when a frame has been fully processed.

## Operation
- Word order: even address = first operand, odd address = second operand of a pair; word k written to address k, k = 0..WORDS-1.
- States: IDLE, FILL, SETTLE, KICK, WAIT, DONE.
- IDLE: `in_ready`=0; `arm`=1 -> FILL, address counter cleared to 0.
- FILL: `in_ready`=1; accept when `in_valid & in_ready`; on accept, register write of word to current address, increment address. Accept of word WORDS-1 -> SETTLE, address wraps to 0. `in_valid` low stalls indefinitely; no timeout.
- SETTLE: `in_ready`=0; last registered write is on the port this cycle -> KICK.
- KICK: `start`=1 for exactly one cycle -> WAIT.
- WAIT: `in_ready`=0; `mult_done`=1 -> DONE.
- DONE: `frame_done`=1 for one cycle -> IDLE.
- `arm` outside IDLE ignored; `mult_done` outside WAIT ignored; `in_valid` while `in_ready`=0 causes no write.
- Reset (any time, incl. mid-FILL or WAIT): state IDLE, address 0; all outputs 0 (`in_ready`, `wr_en`, `wr_addr`, `wr_data`, `start`, `busy`, `frame_done`); partially written frame abandoned, not resumed.

## Timing
- Word accepted at edge t -> `wr_en`/`wr_addr`/`wr_data` valid during cycle t+1; memory captures at edge ending t+1.
- Last word accepted in cycle t -> SETTLE t+1 (last write) -> `start` high in t+2 only.
- `start` is a single-cycle pulse, never held, so the controller leaves its init state on the following cycle.
- `mult_done` seen in cycle u -> `frame_done` in u+1 -> IDLE in u+2; earliest next `arm` acceptance in u+2.
- Minimum frame latency arm->start: WORDS+2 cycles with `in_valid` held high.
- `busy` is combinational from state; all other outputs registered.

## Configuration
- `OPERAND_LOADER_AUTO_REARM_EN`: when defined, DONE -> FILL directly (address 0) without waiting for `arm`, enabling back-to-back frames; `arm` then needed only once after reset. When undefined, DONE -> IDLE and each frame requires its own `arm`.

## Structure
- Shared package: state encoding constants (IDLE..DONE), default `DATA_W`, `PAIRS`.
- One sub-module: `wr_addr_counter` (ADDR_W-bit counter, clear, increment, terminal-count flag at WORDS-1).
- FSM, handshake and registered write port in the top module.

## Test plan
- Reset then `arm`, 16 words 0x0001..0x0010 with `in_valid` continuous -> writes addr 0..15 with matching data, `start` exactly once, 2 cycles after last accept.
- Drop `in_valid` for 5 cycles after word 3 -> no `wr_en` during gap, addresses remain contiguous, `start` delayed by 5 cycles.
- `in_valid`=1 and `arm` pulses during WAIT -> `in_ready`=0, no writes, no extra `start`; `mult_done` -> `frame_done` next cycle, then IDLE.
- Assert `rst` after word 7 of a frame -> all outputs 0 immediately; re-`arm` -> first write at address 0.
- Spurious `mult_done` in IDLE/FILL -> no `frame_done`, FILL continues unaffected.
- With `OPERAND_LOADER_AUTO_REARM_EN`: two frames back-to-back, single `arm` -> second frame writes from address 0, two `start` and two `frame_done` pulses.
